// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcode set,
// instruction field positions and opcode classification helpers.
package alu_sequencer_pkg;

  localparam int OPC_W = 8;

  // ALU opcode encodings. Immediate variants sit at 0x1x.
  typedef enum logic [OPC_W-1:0] {
    ALU_NOP   = 8'h00,
    ALU_ADD   = 8'h01,
    ALU_SUB   = 8'h02,
    ALU_AND   = 8'h03,
    ALU_OR    = 8'h04,
    ALU_XOR   = 8'h05,
    ALU_SHL   = 8'h06,
    ALU_SHR   = 8'h07,
    ALU_ADD_I = 8'h11,
    ALU_SUB_I = 8'h12,
    ALU_AND_I = 8'h13,
    ALU_OR_I  = 8'h14,
    ALU_XOR_I = 8'h15
  } alu_op_e;

  // Opcode driven on the ALU port out of reset and for bubbles.
  localparam logic [OPC_W-1:0] OP_RESET = ALU_NOP;

  // Instruction word field positions (LSB of each field).
  localparam int INSTR_OP_LSB  = 24;
  localparam int INSTR_RD_LSB  = 20;
  localparam int INSTR_RA_LSB  = 16;
  localparam int INSTR_RB_LSB  = 12;
  localparam int INSTR_SH_LSB  = 7;
  localparam int INSTR_IMM_LSB = 0;
  localparam int INSTR_IMM_W   = 16;

  // Opcodes whose B operand comes from the zero-extended immediate.
  function automatic logic is_imm(input logic [OPC_W-1:0] op);
    case (op)
      ALU_ADD_I, ALU_SUB_I, ALU_AND_I, ALU_OR_I, ALU_XOR_I: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Full set of opcodes the sequencer will issue; anything else is dropped.
  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    case (op)
      ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_SHL, ALU_SHR:                            return 1'b1;
      default:                                              return is_imm(op);
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, whole array cleared by synchronous reset.
module alu_regfile
  #(parameter int N  = 16,
    parameter int AW = 4)
  (input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] i_ra_addr,
   output logic [N-1:0]  o_ra_data,
   input  logic [AW-1:0] i_rb_addr,
   output logic [N-1:0]  o_rb_data,
   input  logic          i_we,
   input  logic [AW-1:0] i_wa,
   input  logic [N-1:0]  i_wd);

  logic [N-1:0] r_mem [2**AW];

  // Storage update: clear on reset, otherwise write any register except r0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  // Read ports: register 0 always reads as zero.
  always_comb begin
    o_ra_data = (i_ra_addr == '0) ? '0 : r_mem[i_ra_addr];
    o_rb_data = (i_rb_addr == '0) ? '0 : r_mem[i_rb_addr];
  end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback front end for the external ALU. Two registered stages:
// E drives the ALU ports, W holds the captured result on the res_* port.
module alu_sequencer
  import alu_sequencer_pkg::*;
  #(parameter int N  = 16,
    parameter int C  = 8,
    parameter int S  = 5,
    parameter int AW = 4)
  (input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   output logic [C-1:0]  alu_opcode,
   output logic [N-1:0]  alu_a,
   output logic [N-1:0]  alu_b,
   output logic [S-1:0]  alu_shift,
   input  logic [N-1:0]  alu_y,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [N-1:0]  res_data,
   output logic [AW-1:0] res_rd,
   output logic          err_illegal);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high. Producers hold valid and payload stable until that edge;
  // ready may depend combinationally on downstream ready (in_ready follows
  // res_ready), valid never depends on ready.

  // E stage
  logic          r_valid_e;
  logic [C-1:0]  r_op_e;
  logic [N-1:0]  r_a_e;
  logic [N-1:0]  r_b_e;
  logic [S-1:0]  r_shift_e;
  logic [AW-1:0] r_rd_e;
  // W stage
  logic          r_valid_w;
  logic [N-1:0]  r_y_w;
  logic [AW-1:0] r_rd_w;
  logic          r_err;

  // Decode
  logic          w_advance;
  logic          w_accept;
  logic          w_issue;
  logic          w_we;
  logic [C-1:0]  w_op;
  logic [AW-1:0] w_rd;
  logic [AW-1:0] w_ra;
  logic [AW-1:0] w_rb;
  logic [S-1:0]  w_sh;
  logic [N-1:0]  w_imm;
  logic [N-1:0]  w_rf_a;
  logic [N-1:0]  w_rf_b;
  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;

  assign w_op  = in_instr[INSTR_OP_LSB +: C];
  assign w_rd  = in_instr[INSTR_RD_LSB +: AW];
  assign w_ra  = in_instr[INSTR_RA_LSB +: AW];
  assign w_rb  = in_instr[INSTR_RB_LSB +: AW];
  assign w_sh  = in_instr[INSTR_SH_LSB +: S];
  assign w_imm = N'(in_instr[INSTR_IMM_LSB +: INSTR_IMM_W]);

  // The pipe only stalls when W holds a result the consumer refuses.
  assign w_advance = !(r_valid_w && !res_ready);
  assign in_ready  = w_advance;
  assign w_accept  = in_valid && w_advance;
  // NOP and illegal opcodes are accepted but enter E as bubbles.
  assign w_issue   = w_accept && is_legal(w_op) && (w_op != OP_RESET);
  assign w_we      = r_valid_w && res_ready;

  alu_regfile #(.N(N), .AW(AW)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_ra_addr (w_ra),
    .o_ra_data (w_rf_a),
    .i_rb_addr (w_rb),
    .o_rb_data (w_rf_b),
    .i_we      (w_we),
    .i_wa      (r_rd_w),
    .i_wd      (r_y_w)
  );

  // Youngest producer wins: E result, then W result, then the file.
  // Register 0 is never forwarded.
  function automatic logic [N-1:0] fwd_mux(
    input logic [AW-1:0] src,
    input logic [N-1:0]  rf_val,
    input logic          ve,
    input logic [AW-1:0] rde,
    input logic [N-1:0]  ye,
    input logic          vw,
    input logic [AW-1:0] rdw,
    input logic [N-1:0]  yw);
    if (src == '0)                return '0;
    else if (ve && (rde == src))  return ye;
    else if (vw && (rdw == src))  return yw;
    else                          return rf_val;
  endfunction

  // Operand selection with forwarding; immediate ops take B from imm.
  always_comb begin
    w_a = fwd_mux(w_ra, w_rf_a, r_valid_e, r_rd_e, alu_y, r_valid_w, r_rd_w, r_y_w);
    w_b = fwd_mux(w_rb, w_rf_b, r_valid_e, r_rd_e, alu_y, r_valid_w, r_rd_w, r_y_w);
    if (is_imm(w_op)) w_b = w_imm;
  end

  // E stage: load a decoded instruction or a bubble whenever the pipe moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_e <= 1'b0;
      r_op_e    <= OP_RESET;
      r_a_e     <= '0;
      r_b_e     <= '0;
      r_shift_e <= '0;
      r_rd_e    <= '0;
    end else if (w_advance) begin
      r_valid_e <= w_issue;
      r_op_e    <= w_issue ? w_op : OP_RESET;
      r_a_e     <= w_issue ? w_a  : '0;
      r_b_e     <= w_issue ? w_b  : '0;
      r_shift_e <= w_issue ? w_sh : '0;
      r_rd_e    <= w_issue ? w_rd : '0;
    end
  end

  // W stage: capture the ALU result from E; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_w <= 1'b0;
      r_y_w     <= '0;
      r_rd_w    <= '0;
    end else if (w_advance) begin
      r_valid_w <= r_valid_e;
      r_y_w     <= alu_y;
      r_rd_w    <= r_rd_e;
    end
  end

  // One-cycle pulse after an illegal opcode is dropped at accept.
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_accept && !is_legal(w_op);
  end

  assign alu_opcode  = r_op_e;
  assign alu_a       = r_a_e;
  assign alu_b       = r_b_e;
  assign alu_shift   = r_shift_e;
  assign res_valid   = r_valid_w;
  assign res_data    = r_y_w;
  assign res_rd      = r_rd_w;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model
// (ADD: saturating a + (b << shift); ADD_I: saturating a + b).
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_shift;
  logic [15:0] alu_y;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [3:0]  res_rd;
  logic        err_illegal;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int waits;

  logic [19:0] exp_q[$];

  alu_sequencer #(.N(16), .C(8), .S(5), .AW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_shift   (alu_shift),
    .alu_y       (alu_y),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_rd      (res_rd),
    .err_illegal (err_illegal)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU
  logic [15:0] m_bs;
  int          m_sum;
  always_comb begin
    m_bs  = '0;
    m_sum = 0;
    case (alu_opcode)
      ALU_ADD:   begin m_bs = alu_b << alu_shift; m_sum = $signed(alu_a) + $signed(m_bs); end
      ALU_ADD_I: m_sum = $signed(alu_a) + $signed(alu_b);
      default:   m_sum = 0;
    endcase
    if (m_sum > 32767)       alu_y = 16'h7FFF;
    else if (m_sum < -32768) alu_y = 16'h8000;
    else                     alu_y = m_sum[15:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction, wait (bounded) for in_ready, transfer on the edge.
  task automatic issue(input logic [31:0] instr, output int nw);
    in_valid = 1'b1;
    in_instr = instr;
    nw = 0;
    while (!in_ready && nw < 20) begin
      step(1);
      nw++;
    end
    check("issue_ready", in_ready, 1'b1);
    step(1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] mk_r(input logic [7:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [4:0] sh);
    return {op, rd, ra, rb, sh, 7'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [7:0] op, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [15:0] imm);
    return {op, rd, ra, imm};
  endfunction

  // Scoreboard: every accepted result must match the head of exp_q in order.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {res_rd, res_data}, 20'hFFFFF);
      end else begin
        check("sb_result", {res_rd, res_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;
    step(3);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_alu_opcode", alu_opcode, ALU_NOP);
    check("rst_alu_a", alu_a, 16'h0);
    check("rst_res_data", res_data, 16'h0);
    check("rst_err", err_illegal, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;

    // Single ADD_I: latency to res_valid
    exp_q.push_back({4'd1, 16'h0005});
    issue(mk_i(ALU_ADD_I, 1, 0, 16'h0005), waits);
    check("t1_alu_opcode", alu_opcode, ALU_ADD_I);
    check("t1_alu_b", alu_b, 16'h0005);
    check("t1_res_valid_early", res_valid, 1'b0);
    step(1);
    check("t1_res_valid", res_valid, 1'b1);
    check("t1_res_data", res_data, 16'h0005);
    check("t1_res_rd", res_rd, 4'd1);
    step(2);

    // Back-to-back dependent: E forwarding
    exp_q.push_back({4'd1, 16'h0005});
    exp_q.push_back({4'd2, 16'h000F});
    issue(mk_i(ALU_ADD_I, 1, 0, 16'h0005), waits);
    issue(mk_r(ALU_ADD, 2, 1, 1, 1), waits);
    check("t2_no_stall", waits, 0);
    check("t2_alu_a_fwd", alu_a, 16'h0005);
    check("t2_alu_b_fwd", alu_b, 16'h0005);
    check("t2_alu_shift", alu_shift, 5'd1);
    step(1);
    check("t2_res_data", res_data, 16'h000F);
    check("t2_res_rd", res_rd, 4'd2);
    step(2);

    // Saturation
    exp_q.push_back({4'd3, 16'h7FFF});
    exp_q.push_back({4'd3, 16'h7FFF});
    issue(mk_i(ALU_ADD_I, 3, 0, 16'h7FFF), waits);
    issue(mk_i(ALU_ADD_I, 3, 3, 16'h0001), waits);
    check("t3_alu_a_fwd", alu_a, 16'h7FFF);
    check("t3_first_data", res_data, 16'h7FFF);
    step(1);
    check("t3_sat_data", res_data, 16'h7FFF);
    step(2);

    // Backpressure
    res_ready = 1'b0;
    exp_q.push_back({4'd4, 16'h0001});
    exp_q.push_back({4'd5, 16'h0002});
    exp_q.push_back({4'd6, 16'h0003});
    issue(mk_i(ALU_ADD_I, 4, 0, 16'h0001), waits);
    issue(mk_i(ALU_ADD_I, 5, 0, 16'h0002), waits);
    in_valid = 1'b1;
    in_instr = mk_i(ALU_ADD_I, 6, 0, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      check("t4_in_ready_low", in_ready, 1'b0);
      check("t4_res_hold", {res_valid, res_rd, res_data}, {1'b1, 4'd4, 16'h0001});
      check("t4_alu_hold", {alu_opcode, alu_b}, {ALU_ADD_I, 16'h0002});
      step(1);
    end
    res_ready = 1'b1;
    #1;
    check("t4_in_ready_release", in_ready, 1'b1);
    step(1);
    in_valid = 1'b0;
    check("t4_second", {res_rd, res_data}, {4'd5, 16'h0002});
    check("t4_alu_b_third", alu_b, 16'h0003);
    step(1);
    check("t4_third", {res_rd, res_data}, {4'd6, 16'h0003});
    step(2);

    // Register 0: emitted, never stored or forwarded
    exp_q.push_back({4'd0, 16'h0009});
    exp_q.push_back({4'd7, 16'h0000});
    issue(mk_i(ALU_ADD_I, 0, 0, 16'h0009), waits);
    issue(mk_i(ALU_ADD_I, 7, 0, 16'h0000), waits);
    check("t5_r0_no_fwd", alu_a, 16'h0000);
    check("t5_rd0_emit", {res_valid, res_rd, res_data}, {1'b1, 4'd0, 16'h0009});
    step(1);
    check("t5_r7", {res_rd, res_data}, {4'd7, 16'h0000});
    step(2);

    // Illegal opcode
    issue({8'hFF, 24'h123456}, waits);
    check("t5_err_pulse", err_illegal, 1'b1);
    check("t5_ill_bubble", alu_opcode, ALU_NOP);
    check("t5_ill_in_ready", in_ready, 1'b1);
    step(1);
    check("t5_err_clear", err_illegal, 1'b0);
    check("t5_ill_no_res", res_valid, 1'b0);

    // NOP retires nothing
    issue(mk_i(ALU_NOP, 8, 0, 16'h0004), waits);
    step(1);
    check("t5_nop_no_res", res_valid, 1'b0);
    check("t5_nop_no_err", err_illegal, 1'b0);

    // Readback of registers retired under backpressure
    exp_q.push_back({4'd9, 16'h0001});
    exp_q.push_back({4'd10, 16'h0008});
    issue(mk_i(ALU_ADD_I, 9, 4, 16'h0000), waits);
    check("rb_r4", alu_a, 16'h0001);
    issue(mk_r(ALU_ADD, 10, 5, 6, 1), waits);
    check("rb_r5_r6", {alu_a, alu_b}, {16'h0002, 16'h0003});
    step(1);
    check("rb_r10", res_data, 16'h0008);
    step(2);

    // Reset with E and W both full
    res_ready = 1'b0;
    issue(mk_i(ALU_ADD_I, 11, 0, 16'h0001), waits);
    issue(mk_i(ALU_ADD_I, 12, 0, 16'h0002), waits);
    check("t6_pre_w_valid", res_valid, 1'b1);
    check("t6_pre_e_op", alu_opcode, ALU_ADD_I);
    reset = 1'b1;
    exp_q.delete();
    step(1);
    check("t6_res_valid", res_valid, 1'b0);
    check("t6_alu_opcode", alu_opcode, ALU_NOP);
    check("t6_zeroes", {alu_a, alu_b, alu_shift, res_data, res_rd}, 57'd0);
    reset = 1'b0;
    res_ready = 1'b1;
    exp_q.push_back({4'd13, 16'h0000});
    issue(mk_i(ALU_ADD_I, 13, 1, 16'h0000), waits);
    check("t6_r1_cleared", alu_a, 16'h0000);
    step(1);
    check("t6_r13", {res_valid, res_rd, res_data}, {1'b1, 4'd13, 16'h0000});
    step(3);

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
